bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous load, prescaled enable, wrap or saturate mode, and terminal-count pulse. Each digit drives an integrated active-low seven-segment decoder. It generalises the team's fixed 8-bit binary T-flip-flop counter into a reusable display-ready counting block for lab top levels: timers, scoreboards and event counters driven from board switches and keys.

## Interface
- DIGITS, 2, number of BCD digits; legal range 1..8
- PRESCALE, 1, number of enabled cycles per count step; legal range 1..65535
- SATURATE, 0, boundary mode; 0 = wrap, 1 = hold at boundary

- clock  input  1  single clock; all state changes on its rising edge
- clear  input  1  asynchronous, active-low reset
- enable  input  1  count enable; qualifies the prescaler
- up  input  1  direction; 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe
- load_value  input  4*DIGITS  BCD value to load; digit k is at [4k+3:4k]
- count  output  4*DIGITS  registered BCD count; digit 0 is least significant
- tc  output  1  registered terminal-count pulse
- hex  output  7*DIGITS  active-low segments; digit k is at [7k+6:7k]; bit order g..a, with a at the LSB

## Operation
- Reset while clear is low, applied asynchronously and held:
  - count = 0
  - prescaler = 0
  - tc = 0
  - every hex digit = 7'b1000000
- Priority per rising edge: clear, then load, then step, then hold.
- Load:
  - count <= load_value, with any digit greater than 9 clamped to 9.
  - prescaler <= 0 and tc <= 0.
  - enable and up are ignored that cycle.
- Prescaler:
  - Width is ceil(log2(PRESCALE)), minimum 1 bit.
  - Increments only on cycles where enable = 1 and load = 0.
  - When it equals PRESCALE-1 with enable = 1, a step occurs and the prescaler returns to 0.
  - enable = 0 freezes the prescaler; it is not cleared.
  - With PRESCALE = 1, every enabled cycle is a step.
- Step, up = 1:
  - Digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit.
  - Boundary is all digits 9. SATURATE = 0 gives all 0; SATURATE = 1 holds all 9.
- Step, up = 0:
  - Digit 0 decrements.
  - A digit at 0 rolls to 9 and borrows from the next digit.
  - Boundary is all digits 0. SATURATE = 0 gives all 9; SATURATE = 1 holds all 0.
- tc:
  - Set to 1 for exactly one cycle after an edge on which a step was taken from the boundary value for the current direction. This applies whether the count wrapped or saturated.
  - Cleared on every other edge.
  - Under saturation with enable held, tc pulses once per step, not continuously.
- A direction change takes effect on the next step. The prescaler phase is preserved.
- hex is purely combinational from count.
  - Codes 0–9 (hex, g..a): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
  - count never holds a digit above 9. The decoder default for an illegal code is 7'b1111111 (blank).

## Timing
- Step latency: count updates on the edge that completes the PRESCALE-th enabled cycle.
- Load latency: 1 edge.
- tc goes high on the same edge as the boundary step and is visible for one cycle.
- hex follows count with combinational delay only.
- Asynchronous clear mid-prescale discards the prescaler phase. The first step after release needs a full PRESCALE enabled cycles.
- Release of clear takes effect synchronously. The first load or step is on the first rising edge with clear high.
- load and step on the same edge: load wins, no tc.
- load of the boundary value followed by a step toward that boundary: wrap or saturate with a tc pulse.
- All outputs are glitch-free registers except hex.

## Test plan
- Reset and wrap count-up (DIGITS=2, PRESCALE=1, SATURATE=0):
  - Stimulus: clear low, then enable=1, up=1 for 100 cycles.
  - Response: count goes 00→99→00. tc is high only in the cycle after 99→00. hex = {79,40} at count 10.
- Down-count from zero (DIGITS=2, PRESCALE=1, SATURATE=0):
  - Stimulus: from 00, up=0, one step.
  - Response: count = 99 and tc pulses.
  - Follow-on: 10 more steps give count = 89 (the 90→89 borrow is exercised).
- Saturate mode (DIGITS=2, PRESCALE=1, SATURATE=1):
  - Stimulus: load 98, up=1, 4 steps.
  - Response: count goes 99, 99, 99, 99. tc is high after steps 2, 3 and 4 only.
- Prescaler (DIGITS=2, PRESCALE=3):
  - Stimulus: enable pattern 1,1,0,1,1,1,1.
  - Response: count goes 00→01 on the 3rd enabled edge (the 4th clock) and 01→02 on the 6th enabled edge.
- Load behaviour (DIGITS=2):
  - Stimulus: load_value=8'hC5 with load=1 and enable=1 on the same edge.
  - Response: count = 95 and tc = 0.
  - Follow-on: the next step (up=1) gives count = 96.
- Asynchronous clear mid-operation (DIGITS=2, PRESCALE=3):
  - Stimulus: count at 47 with the prescaler at phase 2; assert clear low between edges.
  - Response: count = 00 and hex = {40,40} immediately. After release, the first step needs 3 enabled edges.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: prescaled multi-digit BCD up/down counter with load, wrap/saturate, tc pulse and 7-seg outputs
module bcd_updown_counter #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [7*DIGITS-1:0]   hex
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] psc;
    logic [W-1:0]  stepped;
    logic [W-1:0]  clamped;
    logic [3:0]    d;
    logic          carry;
    logic          boundary;
    logic          last;

    assign last = psc == PW'(PRESCALE - 1);

    // ripple the carry/borrow through the digits; surviving carry means we stepped from the boundary
    always_comb begin
        stepped = count;
        carry = 1'b1;
        d = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            d = count[4*k +: 4];
            if (carry) stepped[4*k +: 4] = up ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
            carry = carry & (up ? d == 4'd9 : d == 4'd0);
        end
        boundary = carry;
    end

    // non-BCD load digits are clamped to 9 so count never holds an illegal code
    always_comb begin
        clamped = load_value;
        for (int k = 0; k < DIGITS; k++)
            clamped[4*k +: 4] = load_value[4*k +: 4] > 4'd9 ? 4'd9 : load_value[4*k +: 4];
    end

    // count, prescaler phase and terminal-count pulse; load beats step
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count <= '0;
            psc   <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= clamped;
            psc   <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= enable && last && boundary;
            if (enable) begin
                psc <= last ? '0 : psc + 1'b1;
                if (last) count <= (SATURATE && boundary) ? count : stepped;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign hex[7*g +: 7] = seg7(count[4*g +: 4]);
    end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: scoreboard bench over three counter configurations
module tb_bcd_updown_counter;
    logic clock = 1'b0, clear = 1'b1, enable = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0]  load_value = 8'h00;
    logic [7:0]  count_a, count_b, count_c;
    logic        tc_a, tc_b, tc_c;
    logic [13:0] hex_a, hex_b, hex_c;
    int errors = 0, checks = 0;

    typedef struct packed {
        logic [1:0] dut;
        logic [7:0] count;
        logic       tc;
    } exp_t;
    exp_t  exp_q[$];
    string name_q[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clock = ~clock;

    bcd_updown_counter #(.DIGITS(2), .PRESCALE(1), .SATURATE(1'b0)) dut_a (
        .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(count_a), .tc(tc_a), .hex(hex_a));
    bcd_updown_counter #(.DIGITS(2), .PRESCALE(1), .SATURATE(1'b1)) dut_b (
        .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(count_b), .tc(tc_b), .hex(hex_b));
    bcd_updown_counter #(.DIGITS(2), .PRESCALE(3), .SATURATE(1'b0)) dut_c (
        .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(count_c), .tc(tc_c), .hex(hex_c));

    function automatic logic [13:0] hex_of(input logic [7:0] c);
        return {seg_tab[c[7:4]], seg_tab[c[3:0]]};
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string nm, input logic [7:0] ac, input logic atc, input logic [13:0] ah,
                         input logic [7:0] ec, input logic etc);
        checks++;
        if (ac !== ec || atc !== etc || ah !== hex_of(ec)) begin
            errors++;
            $display("FAIL %s: got count=%h tc=%b hex=%h, want count=%h tc=%b hex=%h",
                     nm, ac, atc, ah, ec, etc, hex_of(ec));
        end
    endtask

    task automatic cyc(input logic en, input logic u, input logic ld, input logic [7:0] lv,
                       input logic [1:0] dut, input logic [7:0] ec, input logic etc, input string nm);
        @(negedge clock);
        enable = en; up = u; load = ld; load_value = lv;
        @(posedge clock);
        exp_q.push_back(exp_t'{dut, ec, etc});
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t e;
        string nm;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nm = name_q.pop_front();
                case (e.dut)
                    2'd0:    check(nm, count_a, tc_a, hex_a, e.count, e.tc);
                    2'd1:    check(nm, count_b, tc_b, hex_b, e.count, e.tc);
                    default: check(nm, count_c, tc_c, hex_c, e.count, e.tc);
                endcase
            end
        end
    end

    initial begin : stim
        #3 clear = 1'b0;
        #4;
        check("reset_a", count_a, tc_a, hex_a, 8'h00, 1'b0);
        check("reset_c", count_c, tc_c, hex_c, 8'h00, 1'b0);
        @(negedge clock);
        clear = 1'b1;
        for (int i = 1; i <= 100; i++)
            cyc(1, 1, 0, 8'h00, 2'd0, bcd(i % 100), i == 100, "wrap_up");
        cyc(1, 0, 0, 8'h00, 2'd0, 8'h99, 1, "down_from_zero");
        for (int i = 1; i <= 10; i++)
            cyc(1, 0, 0, 8'h00, 2'd0, bcd(99 - i), 0, "down_borrow");
        cyc(0, 1, 1, 8'h98, 2'd1, 8'h98, 0, "sat_load");
        cyc(1, 1, 0, 8'h00, 2'd1, 8'h99, 0, "sat_step1");
        cyc(1, 1, 0, 8'h00, 2'd1, 8'h99, 1, "sat_step2");
        cyc(1, 1, 0, 8'h00, 2'd1, 8'h99, 1, "sat_step3");
        cyc(1, 1, 0, 8'h00, 2'd1, 8'h99, 1, "sat_step4");
        cyc(0, 0, 1, 8'h00, 2'd1, 8'h00, 0, "sat_load_zero");
        cyc(1, 0, 0, 8'h00, 2'd1, 8'h00, 1, "sat_down_hold");
        cyc(0, 1, 1, 8'h00, 2'd2, 8'h00, 0, "psc_load");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h00, 0, "psc_e1");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h00, 0, "psc_e2");
        cyc(0, 1, 0, 8'h00, 2'd2, 8'h00, 0, "psc_idle");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h01, 0, "psc_e3");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h01, 0, "psc_e4");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h01, 0, "psc_e5");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h02, 0, "psc_e6");
        cyc(1, 1, 1, 8'hC5, 2'd0, 8'h95, 0, "load_clamp");
        cyc(1, 1, 0, 8'h00, 2'd0, 8'h96, 0, "load_then_step");
        cyc(1, 1, 1, 8'h99, 2'd0, 8'h99, 0, "load_boundary");
        cyc(1, 1, 0, 8'h00, 2'd0, 8'h00, 1, "boundary_wrap");
        cyc(0, 1, 1, 8'h47, 2'd2, 8'h47, 0, "clr_load");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h47, 0, "clr_ph1");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h47, 0, "clr_ph2");
        @(negedge clock);
        enable = 1'b0;
        #1 clear = 1'b0;
        #1 check("async_clear", count_c, tc_c, hex_c, 8'h00, 1'b0);
        @(negedge clock);
        clear = 1'b1;
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h00, 0, "post_clr1");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h00, 0, "post_clr2");
        cyc(1, 1, 0, 8'h00, 2'd2, 8'h01, 0, "post_clr3");
        @(negedge clock);
        enable = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
